// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the paddle game sequencer:
//   - state_e        : game FSM state encoding (IDLE/SERVE/PLAY/OVER)
//   - DEF_*          : default values for the game_sequencer parameters
//   - PADDLE_*_RST   : paddle coordinates loaded at reset
//   - SCORE_MAX      : saturation value of the binary score
//   - is_move_state(): states in which paddle move requests are accepted
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int DEF_STEP         = 10;
    localparam int DEF_PADDLE_W     = 84;
    localparam int DEF_XMAX         = 639;
    localparam int DEF_YMAX         = 479;
    localparam int DEF_LIVES        = 3;
    localparam int DEF_SERVE_FRAMES = 60;

    localparam logic [9:0] PADDLE_LEFT_RST  = 10'd190;
    localparam logic [9:0] PADDLE_RIGHT_RST = 10'd274;

    localparam logic [9:0] SCORE_MAX  = 10'd999;

    // The score advances once per 2**PRESCALE_W frames of play.
    localparam int PRESCALE_W = 6;

    function automatic logic is_move_state(input state_e s);
        return (s == ST_SERVE) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Produces a registered one-cycle strobe when the video scan position arrives
// at the last pixel of the frame (XMAX, YMAX). A scan position that stays on
// that pixel for several cycles yields only one strobe.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   x          in   current scan column [9:0]
//   y          in   current scan row    [8:0]
//   frame_tick out  end-of-frame strobe, 1 cycle after the arrival
// -----------------------------------------------------------------------------
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int XMAX = DEF_XMAX,
    parameter int YMAX = DEF_YMAX
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       frame_tick
);

    logic at_end;
    logic at_end_q;
    logic tick_q;

    assign at_end = (x == 10'(XMAX)) && (y == 9'(YMAX));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            at_end_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            at_end_q <= at_end;
            // Rising edge of the "on last pixel" condition only.
            tick_q   <= at_end && !at_end_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Top-level game control for a single-paddle ball game. Runs the
// IDLE -> SERVE -> PLAY -> OVER state machine, keeps lives and score, moves
// the paddle once per frame from latched button presses, and drives the
// collision-engine control and blanking signals. Every output is a register.
//
// Ports:
//   clk          in   system clock (only clock)
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse: start a game (IDLE) / return to IDLE (OVER)
//   move_left    in   pulse: request a left paddle move
//   move_right   in   pulse: request a right paddle move
//   x, y         in   scan position from the video driver
//   lose         in   level: ball missed the paddle
//   paddle_left  out  paddle left edge
//   paddle_right out  paddle right edge (always paddle_left + PADDLE_W)
//   ball_rst     out  holds the collision engine in reset
//   ball_run     out  enables ball motion
//   blank        out  forces black pixels
//   lives        out  remaining lives
//   score        out  binary score, saturating at 999
//   state        out  current FSM state (state_e encoding)
//   frame_tick   out  end-of-frame strobe
// -----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int STEP         = DEF_STEP,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int XMAX         = DEF_XMAX,
    parameter int YMAX         = DEF_YMAX,
    parameter int LIVES        = DEF_LIVES,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       move_left,
    input  logic       move_right,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       lose,
    output logic [9:0] paddle_left,
    output logic [9:0] paddle_right,
    output logic       ball_rst,
    output logic       ball_run,
    output logic       blank,
    output logic [1:0] lives,
    output logic [9:0] score,
    output logic [1:0] state,
    output logic       frame_tick
);

    // Serve counter holds 0 .. SERVE_FRAMES-1.
    localparam int SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e               state_q,         state_d;
    logic [1:0]           lives_q,         lives_d;
    logic [9:0]           score_q,         score_d;
    logic [9:0]           paddle_left_q,   paddle_left_d;
    logic [9:0]           paddle_right_q,  paddle_right_d;
    logic [SERVE_W-1:0]   serve_cnt_q,     serve_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q,     prescale_d;
    logic                 pending_left_q,  pending_left_d;
    logic                 pending_right_q, pending_right_d;
    logic                 lose_q;
    logic                 ball_rst_q;
    logic                 ball_run_q;
    logic                 blank_q;

    // -------------------------------------------------------------------------
    // Frame strobe
    // -------------------------------------------------------------------------
    logic tick;

    frame_tick_gen #(
        .XMAX (XMAX),
        .YMAX (YMAX)
    ) u_frame_tick_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .frame_tick (tick)
    );

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    logic        lose_rise;
    logic        move_ok;
    logic        want_left;
    logic        want_right;
    logic [10:0] right_sum;
    logic [9:0]  left_moved;
    logic [9:0]  right_moved;

    // lose history is sampled every cycle, so a level held across a state
    // change never looks like a fresh edge.
    assign lose_rise  = lose && !lose_q;
    assign move_ok    = is_move_state(state_q);

    // A press in the same cycle as the frame strobe still counts for that frame.
    assign want_left  = pending_left_q  || (move_ok && move_left);
    assign want_right = pending_right_q || (move_ok && move_right);

    // Clamp the moving edge first, then derive the partner edge from it; the
    // 11-bit sum keeps the right-edge clamp free of wrap-around.
    assign right_sum   = {1'b0, paddle_right_q} + 11'(STEP);
    assign left_moved  = (paddle_left_q >= 10'(STEP)) ? (paddle_left_q - 10'(STEP)) : 10'd0;
    assign right_moved = (right_sum > 11'(XMAX)) ? 10'(XMAX) : right_sum[9:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets its hold value first so no path through the
    // block leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        lives_d         = lives_q;
        score_d         = score_q;
        paddle_left_d   = paddle_left_q;
        paddle_right_d  = paddle_right_q;
        serve_cnt_d     = serve_cnt_q;
        prescale_d      = prescale_q;
        pending_left_d  = want_left;
        pending_right_d = want_right;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SERVE;
                    lives_d = 2'(LIVES);
                    score_d = 10'd0;
                end
            end

            ST_SERVE: begin
                if (tick) begin
                    if (serve_cnt_q == SERVE_W'(SERVE_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SERVE_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                // A miss wins over a coincident frame strobe: no score step.
                if (lose_rise) begin
                    if (lives_q > 2'd1) begin
                        state_d = ST_SERVE;
                        lives_d = lives_q - 2'd1;
                    end else begin
                        state_d = ST_OVER;
                        lives_d = 2'd0;
                    end
                end else if (tick) begin
                    prescale_d = prescale_q + PRESCALE_W'(1);
                    if ((prescale_q == '1) && (score_q < SCORE_MAX)) begin
                        score_d = score_q + 10'd1;
                    end
                end
            end

            ST_OVER: begin
                if (start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Paddle update: one move per frame, none if both directions pending.
        if (tick && move_ok) begin
            pending_left_d  = 1'b0;
            pending_right_d = 1'b0;
            if (want_left && !want_right) begin
                paddle_left_d  = left_moved;
                paddle_right_d = left_moved + 10'(PADDLE_W);
            end else if (want_right && !want_left) begin
                paddle_right_d = right_moved;
                paddle_left_d  = right_moved - 10'(PADDLE_W);
            end
        end

        // Entering any state starts with no stale requests and fresh counters.
        if (state_d != state_q) begin
            pending_left_d  = 1'b0;
            pending_right_d = 1'b0;
            serve_cnt_d     = '0;
            prescale_d      = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            lives_q         <= 2'(LIVES);
            score_q         <= 10'd0;
            paddle_left_q   <= PADDLE_LEFT_RST;
            paddle_right_q  <= PADDLE_RIGHT_RST;
            serve_cnt_q     <= '0;
            prescale_q      <= '0;
            pending_left_q  <= 1'b0;
            pending_right_q <= 1'b0;
            lose_q          <= 1'b0;
            ball_rst_q      <= 1'b1;
            ball_run_q      <= 1'b0;
            blank_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            score_q         <= score_d;
            paddle_left_q   <= paddle_left_d;
            paddle_right_q  <= paddle_right_d;
            serve_cnt_q     <= serve_cnt_d;
            prescale_q      <= prescale_d;
            pending_left_q  <= pending_left_d;
            pending_right_q <= pending_right_d;
            lose_q          <= lose;
            // Decoded from the next state so they change together with state.
            ball_rst_q      <= (state_d != ST_PLAY);
            ball_run_q      <= (state_d == ST_PLAY);
            blank_q         <= (state_d == ST_OVER);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign paddle_left  = paddle_left_q;
    assign paddle_right = paddle_right_q;
    assign ball_rst     = ball_rst_q;
    assign ball_run     = ball_run_q;
    assign blank        = blank_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign state        = state_q;
    assign frame_tick   = tick;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Self-checking bench for game_sequencer: reset values, a table of scan
// positions for the frame strobe, hand-written game sequences (serve timing,
// lives, paddle clamps, simultaneous moves, lose/frame collision, async reset)
// and a randomized run compared against a frame-level game model.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    localparam int STEP         = 10;
    localparam int PADDLE_W     = 84;
    localparam int XMAX         = 639;
    localparam int YMAX         = 479;
    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 60;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       lose = 1'b0;
    logic [9:0] paddle_left;
    logic [9:0] paddle_right;
    logic       ball_rst;
    logic       ball_run;
    logic       blank;
    logic [1:0] lives;
    logic [9:0] score;
    logic [1:0] state;
    logic       frame_tick;

    game_sequencer #(
        .STEP         (STEP),
        .PADDLE_W     (PADDLE_W),
        .XMAX         (XMAX),
        .YMAX         (YMAX),
        .LIVES        (LIVES),
        .SERVE_FRAMES (SERVE_FRAMES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .move_left    (move_left),
        .move_right   (move_right),
        .x            (x),
        .y            (y),
        .lose         (lose),
        .paddle_left  (paddle_left),
        .paddle_right (paddle_right),
        .ball_rst     (ball_rst),
        .ball_run     (ball_run),
        .blank        (blank),
        .lives        (lives),
        .score        (score),
        .state        (state),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Game model: tracks frames seen in each phase and the paddle as a single
    // left coordinate; the right edge is always left + PADDLE_W.
    // -------------------------------------------------------------------------
    int m_state, m_lives, m_score, m_left, m_serve_ticks, m_play_ticks;
    bit m_tick, m_prev_at, m_prev_lose, m_pl, m_pr;

    task automatic model_reset();
        m_state = M_IDLE; m_lives = LIVES; m_score = 0; m_left = 190;
        m_serve_ticks = 0; m_play_ticks = 0;
        m_tick = 0; m_prev_at = 0; m_prev_lose = 0; m_pl = 0; m_pr = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit ev_tick, lose_edge, at_end, can_move, want_l, want_r;
        int nxt;
        ev_tick   = m_tick;
        lose_edge = lose && !m_prev_lose;
        at_end    = (x == XMAX) && (y == YMAX);
        m_tick    = at_end && !m_prev_at;
        m_prev_at = at_end;
        m_prev_lose = lose;

        can_move = (m_state == M_SERVE) || (m_state == M_PLAY);
        want_l = m_pl || (can_move && move_left);
        want_r = m_pr || (can_move && move_right);
        if (ev_tick && can_move) begin
            if (want_l && !want_r)
                m_left = (m_left - STEP < 0) ? 0 : m_left - STEP;
            else if (want_r && !want_l)
                m_left = (m_left + STEP > XMAX - PADDLE_W) ? XMAX - PADDLE_W : m_left + STEP;
            want_l = 0; want_r = 0;
        end

        nxt = m_state;
        case (m_state)
            M_IDLE: if (start) begin nxt = M_SERVE; m_lives = LIVES; m_score = 0; end
            M_SERVE: if (ev_tick) begin
                m_serve_ticks++;
                if (m_serve_ticks == SERVE_FRAMES) nxt = M_PLAY;
            end
            M_PLAY: if (lose_edge) begin
                if (m_lives > 1) begin nxt = M_SERVE; m_lives--; end
                else begin nxt = M_OVER; m_lives = 0; end
            end else if (ev_tick) begin
                m_play_ticks++;
                if ((m_play_ticks % 64 == 0) && (m_score < 999)) m_score++;
            end
            default: if (start) nxt = M_IDLE;
        endcase

        if (nxt != m_state) begin
            want_l = 0; want_r = 0; m_serve_ticks = 0; m_play_ticks = 0;
        end
        m_pl = want_l; m_pr = want_r; m_state = nxt;
    endtask

    function automatic logic [63:0] model_bundle();
        logic [9:0] l, r;
        l = 10'(m_left);
        r = 10'(m_left + PADDLE_W);
        return {26'd0, 2'(m_state), 2'(m_lives), 10'(m_score), l, r,
                1'(m_state != M_PLAY), 1'(m_state == M_PLAY), 1'(m_state == M_OVER), m_tick};
    endfunction

    function automatic logic [63:0] dut_bundle();
        return {26'd0, state, lives, score, paddle_left, paddle_right,
                ball_rst, ball_run, blank, frame_tick};
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // One full frame: arrive at the last pixel, then leave; the strobe is
    // consumed on the second edge.
    task automatic frame();
        x = 10'(XMAX); y = 9'(YMAX);
        cycle();
        x = '0; y = '0;
        cycle();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic move_frame(input logic l, input logic r);
        move_left = l; move_right = r;
        cycle();
        move_left = 1'b0; move_right = 1'b0;
        frame();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  64'(state),        64'(M_IDLE));
        check({tag, "_pl"},     64'(paddle_left),  64'd190);
        check({tag, "_pr"},     64'(paddle_right), 64'd274);
        check({tag, "_lives"},  64'(lives),        64'(LIVES));
        check({tag, "_score"},  64'(score),        64'd0);
        check({tag, "_brst"},   64'(ball_rst),     64'd1);
        check({tag, "_brun"},   64'(ball_run),     64'd0);
        check({tag, "_blank"},  64'(blank),        64'd0);
        check({tag, "_ftick"},  64'(frame_tick),   64'd0);
    endtask

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       exp_tick;
    } tick_vec_t;

    tick_vec_t tick_tbl[12];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        tick_tbl = '{
            '{10'd0,   9'd0,   1'b0},
            '{10'd639, 9'd479, 1'b1},
            '{10'd639, 9'd479, 1'b0},
            '{10'd639, 9'd479, 1'b0},
            '{10'd639, 9'd479, 1'b0},
            '{10'd0,   9'd0,   1'b0},
            '{10'd639, 9'd479, 1'b1},
            '{10'd638, 9'd479, 1'b0},
            '{10'd639, 9'd479, 1'b1},
            '{10'd639, 9'd478, 1'b0},
            '{10'd639, 9'd479, 1'b1},
            '{10'd0,   9'd0,   1'b0}
        };

        // Reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset_n = 1'b1;
        model_reset();

        // Frame strobe table (IDLE, nothing else reacts)
        for (int i = 0; i < $size(tick_tbl); i++) begin
            x = tick_tbl[i].x; y = tick_tbl[i].y;
            cycle();
            check($sformatf("tbl_tick[%0d]", i), 64'(frame_tick), 64'(tick_tbl[i].exp_tick));
            check($sformatf("tbl_state[%0d]", i), 64'(state), 64'(M_IDLE));
        end

        // Start -> SERVE; 60 frames -> PLAY
        pulse_start();
        check("start_state", 64'(state), 64'(M_SERVE));
        check("start_lives", 64'(lives), 64'd3);
        check("start_score", 64'(score), 64'd0);
        frames(SERVE_FRAMES - 1);
        check("serve59_state", 64'(state), 64'(M_SERVE));
        check("serve59_brst", 64'(ball_rst), 64'd1);
        frame();
        check("serve60_state", 64'(state), 64'(M_PLAY));
        check("serve60_brun", 64'(ball_run), 64'd1);
        check("serve60_brst", 64'(ball_rst), 64'd0);

        // Paddle: 20 left presses in one frame -> a single move
        for (int i = 0; i < 20; i++) begin
            move_left = 1'b1; cycle();
            move_left = 1'b0; cycle();
        end
        check("pend_no_move", 64'(paddle_left), 64'd190);
        frame();
        check("multi_left_pl", 64'(paddle_left), 64'd180);
        check("multi_left_pr", 64'(paddle_right), 64'd264);
        move_frame(1'b1, 1'b1);
        check("both_pl", 64'(paddle_left), 64'd180);
        check("both_pr", 64'(paddle_right), 64'd264);
        for (int i = 0; i < 18; i++) move_frame(1'b1, 1'b0);
        check("left_to0_pl", 64'(paddle_left), 64'd0);
        move_frame(1'b1, 1'b0);
        check("left_clamp0_pl", 64'(paddle_left), 64'd0);
        check("left_clamp0_pr", 64'(paddle_right), 64'd84);
        for (int i = 0; i < 55; i++) move_frame(1'b0, 1'b1);
        check("right550_pl", 64'(paddle_left), 64'd550);
        check("right550_pr", 64'(paddle_right), 64'd634);
        check("score_after76", 64'(score), 64'd1);
        move_frame(1'b0, 1'b1);
        check("right_clamp_pl", 64'(paddle_left), 64'd555);
        check("right_clamp_pr", 64'(paddle_right), 64'd639);
        move_frame(1'b0, 1'b1);
        check("right_hold_pr", 64'(paddle_right), 64'd639);
        for (int i = 0; i < 55; i++) move_frame(1'b1, 1'b0);
        check("left5_pl", 64'(paddle_left), 64'd5);
        check("left5_pr", 64'(paddle_right), 64'd89);
        move_frame(1'b1, 1'b0);
        check("left_clamp_pl", 64'(paddle_left), 64'd0);
        check("left_clamp_pr", 64'(paddle_right), 64'd84);

        // 134 play frames so far; 57 more leave the prescaler one short.
        frames(57);
        check("score_191", 64'(score), 64'd2);

        // Lose edge coinciding with the frame strobe that would have scored
        x = 10'(XMAX); y = 9'(YMAX);
        cycle();
        check("coinc_tick", 64'(frame_tick), 64'd1);
        lose = 1'b1; x = '0; y = '0;
        cycle();
        check("coinc_state", 64'(state), 64'(M_SERVE));
        check("coinc_lives", 64'(lives), 64'd2);
        check("coinc_score", 64'(score), 64'd2);

        // start ignored in SERVE; lose held across SERVE->PLAY is not an edge
        pulse_start();
        check("start_in_serve", 64'(state), 64'(M_SERVE));
        frames(SERVE_FRAMES);
        check("held_lose_state", 64'(state), 64'(M_PLAY));
        check("held_lose_lives", 64'(lives), 64'd2);
        pulse_start();
        check("start_in_play", 64'(state), 64'(M_PLAY));
        lose = 1'b0; cycle();
        lose = 1'b1; cycle();
        check("lose2_state", 64'(state), 64'(M_SERVE));
        check("lose2_lives", 64'(lives), 64'd1);
        frames(SERVE_FRAMES);
        check("serve3_state", 64'(state), 64'(M_PLAY));
        lose = 1'b0; cycle();
        lose = 1'b1; cycle();
        check("over_state", 64'(state), 64'(M_OVER));
        check("over_lives", 64'(lives), 64'd0);
        check("over_blank", 64'(blank), 64'd1);
        check("over_brst", 64'(ball_rst), 64'd1);
        check("over_brun", 64'(ball_run), 64'd0);
        check("over_score", 64'(score), 64'd2);
        lose = 1'b0; cycle();
        lose = 1'b1; cycle();
        check("over_lose_ign", 64'(state), 64'(M_OVER));
        lose = 1'b0;
        move_frame(1'b0, 1'b1);
        check("over_move_ign", 64'(paddle_left), 64'd0);
        pulse_start();
        check("over_to_idle", 64'(state), 64'(M_IDLE));
        check("idle_blank", 64'(blank), 64'd0);

        // Second game: reach score 5, then reset asynchronously mid-PLAY
        pulse_start();
        check("g2_lives", 64'(lives), 64'd3);
        check("g2_score0", 64'(score), 64'd0);
        frames(SERVE_FRAMES);
        frames(320);
        check("g2_state", 64'(state), 64'(M_PLAY));
        check("g2_score5", 64'(score), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // After reset the strobe needs a new arrival at the last pixel
        cycle();
        check("post_rst_notick", 64'(frame_tick), 64'd0);
        x = 10'(XMAX); y = 9'(YMAX);
        cycle();
        check("post_rst_tick", 64'(frame_tick), 64'd1);
        x = '0; y = '0;
        cycle();

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 199) == 0);
            move_left  = ($urandom_range(0, 7) == 0);
            move_right = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) lose = !lose;
            if ($urandom_range(0, 2) == 0) begin
                x = 10'(XMAX); y = 9'(YMAX);
            end else begin
                x = 10'($urandom_range(0, 1023));
                y = 9'($urandom_range(0, 511));
            end
            cycle();
            check($sformatf("rand[%0d]", i), dut_bundle(), model_bundle());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
